logo_renderer: RTL and testbench

- Generates the 12-bit pixel colour consumed by the VGA timing controller.
- Holds a rectangular logo's top-left position and direction, and moves it once per N frames on the controller's end-of-frame refresh pulse.
- Reflects the logo off the 640x480 screen edges.
- Colours each requested (x,y) pixel as logo or background.

---
 rtl/logo_renderer.sv | 181 ++++++++++++++++++
 tb/tb_logo_renderer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logo_renderer.sv
// Bouncing-logo pixel generator: reflects a rectangle off the screen edges and colours each (x,y) request.
// Optional macro LOGO_COLOR_CYCLE_EN: logo colour steps through an 8-entry palette on every reflecting move.
module logo_renderer #(
  parameter int          SCREEN_W   = 640,
  parameter int          SCREEN_H   = 480,
  parameter int          LOGO_W     = 64,
  parameter int          LOGO_H     = 32,
  parameter int          STEP       = 2,
  parameter int          FRAME_DIV  = 1,
  parameter int          INIT_X     = 100,
  parameter int          INIT_Y     = 100,
  parameter logic [11:0] LOGO_COLOR = 12'hF00,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        refresh,
  input  logic        move_en,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  output logic [11:0] rgb,
  output logic        bounce,
  output logic        corner_hit
);

  localparam logic [10:0] MAX_X  = 11'(SCREEN_W - LOGO_W);
  localparam logic [10:0] MAX_Y  = 11'(SCREEN_H - LOGO_H);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam int          DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  // bit0 set = moving left, bit1 set = moving up
  typedef enum logic [1:0] {
    DR = 2'b00,
    DL = 2'b01,
    UR = 2'b10,
    UL = 2'b11
  } dir_e;

  dir_e             dir_q, dir_d;
  logic [9:0]       pos_x_q, pos_x_d;
  logic [8:0]       pos_y_q, pos_y_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             bounce_q, corner_q;
  logic [11:0]      rgb_q, rgb_d;
  logic [11:0]      logo_rgb;
  logic             move, refl_x, refl_y;
  logic [10:0]      sum_x, sum_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q    <= DR;
      pos_x_q  <= 10'(INIT_X);
      pos_y_q  <= 9'(INIT_Y);
      div_q    <= '0;
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      rgb_q    <= 12'h000;
    end else begin
      dir_q    <= dir_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      div_q    <= div_d;
      bounce_q <= move & (refl_x | refl_y);
      corner_q <= move & refl_x & refl_y;
      rgb_q    <= rgb_d;
    end
  end

  always_comb begin
    dir_d   = dir_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    div_d   = div_q;
    move    = 1'b0;
    refl_x  = 1'b0;
    refl_y  = 1'b0;
    sum_x   = {1'b0, pos_x_q} + STEP_W;
    sum_y   = {2'b00, pos_y_q} + STEP_W;

    if (refresh && move_en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        move  = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    if (move) begin
      if (!dir_q[0]) begin
        if (sum_x >= MAX_X) begin
          pos_x_d = MAX_X[9:0];
          refl_x  = 1'b1;
        end else begin
          pos_x_d = sum_x[9:0];
        end
      end else begin
        if ({1'b0, pos_x_q} <= STEP_W) begin
          pos_x_d = '0;
          refl_x  = 1'b1;
        end else begin
          pos_x_d = pos_x_q - STEP_W[9:0];
        end
      end

      if (!dir_q[1]) begin
        if (sum_y >= MAX_Y) begin
          pos_y_d = MAX_Y[8:0];
          refl_y  = 1'b1;
        end else begin
          pos_y_d = sum_y[8:0];
        end
      end else begin
        if ({2'b00, pos_y_q} <= STEP_W) begin
          pos_y_d = '0;
          refl_y  = 1'b1;
        end else begin
          pos_y_d = pos_y_q - STEP_W[8:0];
        end
      end

      dir_d = dir_e'({dir_q[1] ^ refl_y, dir_q[0] ^ refl_x});
    end
  end

`ifdef LOGO_COLOR_CYCLE_EN
  logic [2:0] cidx_q, cidx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cidx_q <= 3'd0;
    end else begin
      cidx_q <= cidx_d;
    end
  end

  always_comb begin
    cidx_d = cidx_q;
    if (move && (refl_x || refl_y)) begin
      cidx_d = cidx_q + 3'd1;
    end
  end

  always_comb begin
    logo_rgb = 12'hF00;
    case (cidx_q)
      3'd0: logo_rgb = 12'hF00;
      3'd1: logo_rgb = 12'h0F0;
      3'd2: logo_rgb = 12'h00F;
      3'd3: logo_rgb = 12'hFF0;
      3'd4: logo_rgb = 12'h0FF;
      3'd5: logo_rgb = 12'hF0F;
      3'd6: logo_rgb = 12'hFFF;
      3'd7: logo_rgb = 12'hF80;
      default: logo_rgb = 12'hF00;
    endcase
  end
`else
  assign logo_rgb = LOGO_COLOR;
`endif

  logic [10:0] x_w, y_w, px_w, py_w;
  logic        in_x, in_y;

  // The compare always sees the registered (pre-move) position.
  always_comb begin
    x_w   = {1'b0, x};
    y_w   = {2'b00, y};
    px_w  = {1'b0, pos_x_q};
    py_w  = {2'b00, pos_y_q};
    in_x  = (x_w < 11'(SCREEN_W)) && (x_w >= px_w) && (x_w < px_w + 11'(LOGO_W));
    in_y  = (y_w < 11'(SCREEN_H)) && (y_w >= py_w) && (y_w < py_w + 11'(LOGO_H));
    rgb_d = (in_x && in_y) ? logo_rgb : BG_COLOR;
  end

  assign rgb        = rgb_q;
  assign bounce     = bounce_q;
  assign corner_hit = corner_q;

endmodule

// File: tb/tb_logo_renderer.sv
// Randomised self-checking bench for logo_renderer: three instances (default, corner start, divided frame rate).
module tb_logo_renderer;

  localparam int SW = 640;
  localparam int SH = 480;
  localparam int LW = 64;
  localparam int LH = 32;
  localparam int ST = 2;
  localparam int N  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        refresh = 1'b0;
  logic        move_en = 1'b0;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic [11:0] rgb_a [N];
  logic        bounce_a [N];
  logic        corner_a [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logo_renderer u_dut0 (
    .clk(clk), .rst_n(rst_n), .refresh(refresh), .move_en(move_en), .x(x), .y(y),
    .rgb(rgb_a[0]), .bounce(bounce_a[0]), .corner_hit(corner_a[0])
  );

  logo_renderer #(.INIT_X(575), .INIT_Y(447)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .refresh(refresh), .move_en(move_en), .x(x), .y(y),
    .rgb(rgb_a[1]), .bounce(bounce_a[1]), .corner_hit(corner_a[1])
  );

  logo_renderer #(.FRAME_DIV(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .refresh(refresh), .move_en(move_en), .x(x), .y(y),
    .rgb(rgb_a[2]), .bounce(bounce_a[2]), .corner_hit(corner_a[2])
  );

  // Reference model: position in plain integers, direction as +1/-1 velocity.
  typedef struct {
    int px, py, vx, vy, div, cidx, fdiv, ix, iy;
  } mdl_t;

  mdl_t m [N];

  function automatic logic [11:0] logo_col(int ci);
`ifdef LOGO_COLOR_CYCLE_EN
    case (ci)
      0: return 12'hF00;
      1: return 12'h0F0;
      2: return 12'h00F;
      3: return 12'hFF0;
      4: return 12'h0FF;
      5: return 12'hF0F;
      6: return 12'hFFF;
      default: return 12'hF80;
    endcase
`else
    return (ci >= 0) ? 12'hF00 : 12'hF00;
`endif
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m[i].px = m[i].ix; m[i].py = m[i].iy;
      m[i].vx = 1;       m[i].vy = 1;
      m[i].div = 0;      m[i].cidx = 0;
    end
  endtask

  function automatic logic [11:0] model_pix(int i, int xv, int yv);
    if (xv < SW && yv < SH && xv >= m[i].px && xv < m[i].px + LW &&
        yv >= m[i].py && yv < m[i].py + LH)
      return logo_col(m[i].cidx);
    return 12'h000;
  endfunction

  task automatic model_step(input int i, input bit rf, input bit me, output bit b, output bit c);
    bit rx, ry;
    b = 1'b0; c = 1'b0; rx = 1'b0; ry = 1'b0;
    if (!(rf && me)) return;
    m[i].div = m[i].div + 1;
    if (m[i].div < m[i].fdiv) return;
    m[i].div = 0;
    if (m[i].vx > 0) begin
      if (m[i].px + ST >= SW - LW) begin m[i].px = SW - LW; rx = 1'b1; end
      else m[i].px = m[i].px + ST;
    end else begin
      if (m[i].px <= ST) begin m[i].px = 0; rx = 1'b1; end
      else m[i].px = m[i].px - ST;
    end
    if (m[i].vy > 0) begin
      if (m[i].py + ST >= SH - LH) begin m[i].py = SH - LH; ry = 1'b1; end
      else m[i].py = m[i].py + ST;
    end else begin
      if (m[i].py <= ST) begin m[i].py = 0; ry = 1'b1; end
      else m[i].py = m[i].py - ST;
    end
    if (rx) m[i].vx = -m[i].vx;
    if (ry) m[i].vy = -m[i].vy;
    b = rx | ry;
    c = rx & ry;
    if (b) m[i].cidx = (m[i].cidx + 1) % 8;
  endtask

  // One transaction: drive at a falling edge, compare at the next falling edge.
  task automatic cycle(input bit rf, input bit me, input int xv, input int yv);
    logic [11:0] erg [N];
    bit eb [N];
    bit ec [N];
    refresh = rf; move_en = me; x = 10'(xv); y = 9'(yv);
    for (int i = 0; i < N; i++) begin
      if (rst_n) begin
        erg[i] = model_pix(i, xv, yv);
        model_step(i, rf, me, eb[i], ec[i]);
      end else begin
        erg[i] = 12'h000; eb[i] = 1'b0; ec[i] = 1'b0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("rgb%0d", i), 32'(rgb_a[i]), 32'(erg[i]));
      check_val($sformatf("bounce%0d", i), 32'(bounce_a[i]), 32'(eb[i]));
      check_val($sformatf("corner%0d", i), 32'(corner_a[i]), 32'(ec[i]));
    end
    $display("txn t=%0t rst_n=%0b rf=%0b me=%0b x=%0d y=%0d rgb=%h/%h/%h b=%0b%0b%0b c=%0b%0b%0b",
             $time, rst_n, rf, me, xv, yv, rgb_a[0], rgb_a[1], rgb_a[2],
             bounce_a[0], bounce_a[1], bounce_a[2], corner_a[0], corner_a[1], corner_a[2]);
  endtask

  task automatic pick_xy(output int xv, output int yv);
    int t, sel;
    t = int'($urandom_range(0, N - 1));
    sel = int'($urandom_range(0, 4));
    case (sel)
      0: xv = m[t].px - 1;
      1: xv = m[t].px;
      2: xv = m[t].px + LW - 1;
      3: xv = m[t].px + LW;
      default: xv = int'($urandom_range(0, 1023));
    endcase
    sel = int'($urandom_range(0, 4));
    case (sel)
      0: yv = m[t].py - 1;
      1: yv = m[t].py;
      2: yv = m[t].py + LH - 1;
      3: yv = m[t].py + LH;
      default: yv = int'($urandom_range(0, 511));
    endcase
    if (xv < 0) xv = 0;
    if (yv < 0) yv = 0;
  endtask

  task automatic rand_run(input int n);
    int xv, yv;
    bit rf, me;
    for (int k = 0; k < n; k++) begin
      rf = ($urandom_range(0, 3) == 0);
      me = ($urandom_range(0, 9) != 0);
      pick_xy(xv, yv);
      cycle(rf, me, xv, yv);
    end
  endtask

  initial begin
    m[0].ix = 100; m[0].iy = 100; m[0].fdiv = 1;
    m[1].ix = 575; m[1].iy = 447; m[1].fdiv = 1;
    m[2].ix = 100; m[2].iy = 100; m[2].fdiv = 3;
    model_reset();

    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("rst_rgb%0d", i), 32'(rgb_a[i]), 32'h0);
      check_val($sformatf("rst_bounce%0d", i), 32'(bounce_a[i]), 32'h0);
    end
    cycle(1'b1, 1'b1, 100, 100);  // refresh during reset is ignored
    rst_n = 1'b1;

    cycle(1'b0, 1'b1, 100, 100);
    check_val("tp_inside", 32'(rgb_a[0]), 32'hF00);
    cycle(1'b0, 1'b1, 164, 100);
    check_val("tp_right_edge", 32'(rgb_a[0]), 32'h000);
    cycle(1'b0, 1'b1, 100, 132);
    check_val("tp_bottom_edge", 32'(rgb_a[0]), 32'h000);

    cycle(1'b1, 1'b1, 0, 0);
    check_val("tp_no_bounce0", 32'(bounce_a[0]), 32'h0);
    check_val("tp_corner1", 32'(corner_a[1]), 32'h1);
    cycle(1'b0, 1'b1, 101, 102);
    check_val("tp_moved_out", 32'(rgb_a[0]), 32'h000);
    check_val("tp_bounce_1cyc", 32'(bounce_a[1]), 32'h0);
    cycle(1'b0, 1'b1, 102, 102);
    check_val("tp_moved_in", 32'(rgb_a[0]), 32'hF00);
    cycle(1'b0, 1'b1, 576, 448);
`ifdef LOGO_COLOR_CYCLE_EN
    check_val("tp_corner_colour", 32'(rgb_a[1]), 32'h0F0);
`else
    check_val("tp_corner_colour", 32'(rgb_a[1]), 32'hF00);
`endif

    // Two more refreshes complete the divide-by-3 instance's first move.
    cycle(1'b1, 1'b1, 0, 0);
    cycle(1'b0, 1'b1, 100, 100);
    check_val("tp_div_hold", 32'(rgb_a[2]), 32'hF00);
    cycle(1'b1, 1'b1, 0, 0);
    cycle(1'b0, 1'b1, 101, 101);
    check_val("tp_div_moved", 32'(rgb_a[2]), 32'h000);

    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 0, 0);

    rand_run(1000);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("async_rgb%0d", i), 32'(rgb_a[i]), 32'h0);
      check_val($sformatf("async_bounce%0d", i), 32'(bounce_a[i]), 32'h0);
    end
    model_reset();
    @(negedge clk);
    cycle(1'b1, 1'b1, 100, 100);
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 100, 100);
    check_val("post_rst_home", 32'(rgb_a[0]), 32'hF00);
    cycle(1'b1, 1'b1, 0, 0);
    cycle(1'b0, 1'b1, 102, 102);
    check_val("post_rst_move_in", 32'(rgb_a[0]), 32'hF00);
    cycle(1'b0, 1'b1, 101, 102);
    check_val("post_rst_move_out", 32'(rgb_a[0]), 32'h000);

    rand_run(1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
